// File: rtl/spi_master_multi.sv
// spi_master_multi: single-clock SPI master with all four CPOL/CPHA modes,
// runtime SCLK half-period divider, one-hot active-low slave selects and a
// completion pulse. SCLK is a registered output generated on clk.
// Optional build macro SPI_MASTER_LSB_FIRST_EN adds the lsb_first input
// (latched per transfer) for LSB-first shifting; without it transfers are
// MSB-first only.
module spi_master_multi #(
    parameter int unsigned SPI_MAXLEN = 32,
    parameter int unsigned NUM_SS     = 4,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          sreset,
    input  logic                          start_cmd,
    output logic                          spi_drv_rdy,
    input  logic [$clog2(SPI_MAXLEN):0]   n_clks,
    input  logic [DIV_W-1:0]              clk_div,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic [$clog2(NUM_SS)-1:0]     ss_sel,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    output logic [SPI_MAXLEN-1:0]         rx_miso,
    output logic                          rx_valid,
    output logic                          SCLK,
    output logic                          MOSI,
    input  logic                          MISO,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic                          lsb_first,
`endif
    output logic [NUM_SS-1:0]             SS_N
);

    localparam int unsigned CW = $clog2(SPI_MAXLEN) + 1;  // bit count / pointer width
    localparam int unsigned IW = $clog2(SPI_MAXLEN);      // bit index width
    localparam int unsigned HW = CW + 1;                  // half-period count width

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD} state_t;

    state_t                 state_q, state_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [CW-1:0]          n_q, n_d;
    logic                   cpol_q, cpol_d;
    logic                   cpha_q, cpha_d;
    logic [SPI_MAXLEN-1:0]  tx_q, tx_d;
    logic [CW-1:0]          ptr_q, ptr_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [CW-1:0]          bcnt_q, bcnt_d;
    logic [SPI_MAXLEN-1:0]  rxsh_q, rxsh_d;
    logic                   rdy_q, rdy_d;
    logic [NUM_SS-1:0]      ss_n_q, ss_n_d;
    logic                   sclk_q, sclk_d;
    logic                   mosi_q, mosi_d;
    logic [SPI_MAXLEN-1:0]  rx_miso_q, rx_miso_d;
    logic                   rx_valid_q, rx_valid_d;

    logic                   legal_c;
    logic                   accept_c;
    logic                   lsb_c;
    logic                   lsb_in_c;
    logic [DIV_W-1:0]       div_eff_c;
    logic [CW-1:0]          first_c;
    logic [CW-1:0]          ptr_next_c;
    logic [CW-1:0]          rxpos_c;
    logic [HW-1:0]          k_c;
    logic [HW-1:0]          last_hp_c;

`ifdef SPI_MASTER_LSB_FIRST_EN
    logic lsb_q;

    // Bit-order select captured with the rest of the command
    always_ff @(posedge clk) begin
        if (sreset) begin
            lsb_q <= 1'b0;
        end else if (accept_c) begin
            lsb_q <= lsb_first;
        end
    end

    assign lsb_c    = lsb_q;
    assign lsb_in_c = lsb_first;
`else
    assign lsb_c    = 1'b0;
    assign lsb_in_c = 1'b0;
`endif

    // Command qualification and per-transfer derived values
    assign legal_c    = (n_clks != '0) && (32'(n_clks) <= SPI_MAXLEN) && (32'(ss_sel) < NUM_SS);
    assign accept_c   = (state_q == S_IDLE) && rdy_q && start_cmd && legal_c;
    assign div_eff_c  = (clk_div == '0) ? DIV_W'(1) : clk_div;
    assign first_c    = lsb_in_c ? '0 : n_clks - CW'(1);
    assign ptr_next_c = lsb_c ? ptr_q + CW'(1) : ptr_q - CW'(1);
    assign rxpos_c    = lsb_c ? bcnt_q : n_q - CW'(1) - bcnt_q;
    assign k_c        = (state_q == S_SETUP) ? '0 : hcnt_q + HW'(1);
    assign last_hp_c  = {n_q, 1'b0} - HW'(1);

    // State and output registers
    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= DIV_W'(1);
            n_q        <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_q       <= '0;
            ptr_q      <= '0;
            hcnt_q     <= '0;
            bcnt_q     <= '0;
            rxsh_q     <= '0;
            rdy_q      <= 1'b1;
            ss_n_q     <= '1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_miso_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            n_q        <= n_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            hcnt_q     <= hcnt_d;
            bcnt_q     <= bcnt_d;
            rxsh_q     <= rxsh_d;
            rdy_q      <= rdy_d;
            ss_n_q     <= ss_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_miso_q  <= rx_miso_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    // Next-state: phase timing, SCLK toggling, MOSI shifting and MISO sampling
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        n_d        = n_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_d       = tx_q;
        ptr_d      = ptr_q;
        hcnt_d     = hcnt_q;
        bcnt_d     = bcnt_q;
        rxsh_d     = rxsh_q;
        rdy_d      = rdy_q;
        ss_n_d     = ss_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_miso_d  = rx_miso_q;
        rx_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                rdy_d  = 1'b1;
                ss_n_d = '1;
                mosi_d = 1'b0;
                sclk_d = cpol;
                if (accept_c) begin
                    state_d = S_SETUP;
                    rdy_d   = 1'b0;
                    div_d   = div_eff_c;
                    cnt_d   = div_eff_c - DIV_W'(1);
                    n_d     = n_clks;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    tx_d    = tx_data;
                    hcnt_d  = '0;
                    bcnt_d  = '0;
                    rxsh_d  = '0;
                    ss_n_d  = ~(NUM_SS'(1) << ss_sel);
                    if (!cpha) begin
                        // Mode with leading-edge sampling: first bit valid during SETUP
                        mosi_d = tx_data[IW'(first_c)];
                        ptr_d  = lsb_in_c ? first_c + CW'(1) : first_c - CW'(1);
                    end else begin
                        ptr_d  = first_c;
                    end
                end
            end
            S_SETUP, S_XFER: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    cnt_d = div_q - DIV_W'(1);
                    if ((state_q == S_XFER) && (hcnt_q == last_hp_c)) begin
                        state_d = S_HOLD;
                    end else begin
                        // Entering half-period k: even k is a leading edge, odd k trailing
                        state_d = S_XFER;
                        hcnt_d  = k_c;
                        sclk_d  = ~sclk_q;
                        if (k_c[0] == cpha_q) begin
                            rxsh_d[IW'(rxpos_c)] = MISO;
                            bcnt_d = bcnt_q + CW'(1);
                        end else if (cpha_q || (k_c != last_hp_c)) begin
                            mosi_d = tx_q[IW'(ptr_q)];
                            ptr_d  = ptr_next_c;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else begin
                    state_d    = S_IDLE;
                    ss_n_d     = '1;
                    rx_miso_d  = rxsh_q;
                    rx_valid_d = 1'b1;
                    rdy_d      = 1'b1;
                    mosi_d     = 1'b0;
                    sclk_d     = cpol_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign spi_drv_rdy = rdy_q;
    assign SS_N        = ss_n_q;
    assign SCLK        = sclk_q;
    assign MOSI        = mosi_q;
    assign rx_miso     = rx_miso_q;
    assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: a behavioural SPI slave watches
// the pins, echoes or supplies MISO, and records what it received; each test
// task compares against expectations computed from the transfer parameters.
module tb_spi_master_multi;

    localparam int NSS = 3;
    localparam int DW  = 16;

    logic        clk = 1'b0;
    logic        sreset;
    logic        start_cmd;
    logic        spi_drv_rdy;
    logic [5:0]  n_clks;
    logic [DW-1:0] clk_div;
    logic        cpol;
    logic        cpha;
    logic [1:0]  ss_sel;
    logic [31:0] tx_data;
    logic [31:0] rx_miso;
    logic        rx_valid;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [NSS-1:0] SS_N;
`ifdef SPI_MASTER_LSB_FIRST_EN
    logic        lsb_first;
`endif

    int checks = 0;
    int errors = 0;

    // Slave model state
    logic        loop_en = 1'b1;
    logic [31:0] sw = '0;
    int          cur_n = 1;
    logic        cur_cpha = 1'b0;
    logic        cur_lsb = 1'b0;
    logic        slave_bit = 1'b0;
    int          edges = 0;
    int          rises = 0;
    int          sidx = 0;
    int          cap_cnt = 0;
    logic [31:0] cap = '0;
    logic        first_cap = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_ss_all = 1'b1;

    always #5 clk = ~clk;

    assign MISO = loop_en ? MOSI : slave_bit;

    spi_master_multi #(.SPI_MAXLEN(32), .NUM_SS(NSS), .DIV_W(DW)) dut (
        .clk(clk), .sreset(sreset), .start_cmd(start_cmd), .spi_drv_rdy(spi_drv_rdy),
        .n_clks(n_clks), .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .ss_sel(ss_sel),
        .tx_data(tx_data), .rx_miso(rx_miso), .rx_valid(rx_valid), .SCLK(SCLK),
        .MOSI(MOSI), .MISO(MISO),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first(lsb_first),
`endif
        .SS_N(SS_N));

    function automatic logic sbit(input int idx);
        return cur_lsb ? sw[idx] : sw[cur_n - 1 - idx];
    endfunction

    // Behavioural slave: reacts to select and SCLK edges seen on the pins
    always @(negedge clk) begin
        if (prev_ss_all && !(&SS_N)) begin
            edges = 0; rises = 0; sidx = 0; cap_cnt = 0; cap = '0;
            slave_bit = cur_cpha ? 1'b0 : sbit(0);
        end else if (!(&SS_N) && (SCLK !== prev_sclk)) begin
            edges++;
            if (SCLK) rises++;
            if (((edges % 2) == 1) != cur_cpha) begin
                if (cap_cnt == 0) first_cap = MOSI;
                if (cur_lsb) cap[cap_cnt] = MOSI;
                else cap = {cap[30:0], MOSI};
                cap_cnt++;
            end else if (cur_cpha) begin
                slave_bit = sbit(sidx);
                sidx++;
            end else begin
                sidx++;
                if (sidx < cur_n) slave_bit = sbit(sidx);
            end
        end
        prev_sclk = SCLK;
        prev_ss_all = &SS_N;
    end

    // One complete transfer with full checking of timing, pins and data
    task automatic run_xfer(input int n, input int div, input logic pol, input logic pha,
                            input int sel, input logic [31:0] tx, input logic loop,
                            input logic lsb, input logic poke, input logic pulse_chk,
                            input string tag);
        int d, len, cyc, bad_ss;
        logic [31:0] mask, exp_rx, word;
        logic [NSS-1:0] exp_ss;
        d = (div == 0) ? 1 : div;
        len = d * (2 * n + 2);
        mask = 32'((64'd1 << n) - 64'd1);
        word = $urandom;
        sw = word; loop_en = loop; cur_n = n; cur_cpha = pha; cur_lsb = lsb;
        exp_rx = (loop ? tx : word) & mask;
        exp_ss = ~(NSS'(1) << sel);
        n_clks = 6'(n); clk_div = DW'(div); cpol = pol; cpha = pha;
        ss_sel = 2'(sel); tx_data = tx;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = lsb;
`endif
        start_cmd = 1'b1;
        @(posedge clk); #1;
        start_cmd = 1'b0;
        n_clks = 6'($urandom_range(1, 32)); clk_div = DW'($urandom_range(0, 3));
        cpha = ~pha; ss_sel = 2'($urandom_range(0, 2)); tx_data = $urandom;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = ~lsb;
`endif
        cyc = 0; bad_ss = 0;
        while (cyc < len + 10) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 3) start_cmd = 1'b1;
            if (poke && cyc == 4) start_cmd = 1'b0;
            if (cyc == 1) begin
                checks++;
                if (spi_drv_rdy !== 1'b0) begin errors++; $display("FAIL %s busy_rdy: got %b, expected 0", tag, spi_drv_rdy); end
                checks++;
                if (SCLK !== pol) begin errors++; $display("FAIL %s setup_sclk: got %b, expected %b", tag, SCLK, pol); end
            end
            if (rx_valid === 1'b1) break;
            if (SS_N !== exp_ss) bad_ss++;
        end
        start_cmd = 1'b0;
        checks++;
        if (cyc != len + 1) begin errors++; $display("FAIL %s done_cycle: got T+%0d, expected T+%0d", tag, cyc, len + 1); end
        checks++;
        if (rx_miso !== exp_rx) begin errors++; $display("FAIL %s rx_miso: got %h, expected %h", tag, rx_miso, exp_rx); end
        checks++;
        if (spi_drv_rdy !== 1'b1 || SS_N !== '1 || MOSI !== 1'b0) begin
            errors++; $display("FAIL %s done_pins: got rdy=%b ss=%b mosi=%b, expected 1 %b 0", tag, spi_drv_rdy, SS_N, MOSI, {NSS{1'b1}});
        end
        checks++;
        if (SCLK !== pol) begin errors++; $display("FAIL %s done_sclk: got %b, expected %b", tag, SCLK, pol); end
        checks++;
        if (bad_ss != 0) begin errors++; $display("FAIL %s ss_n: %0d cycles off, expected %b throughout", tag, bad_ss, exp_ss); end
        checks++;
        if (edges != 2 * n || rises != n) begin
            errors++; $display("FAIL %s sclk_edges: got %0d/%0d rising, expected %0d/%0d", tag, edges, rises, 2 * n, n);
        end
        checks++;
        if (cap !== (tx & mask)) begin errors++; $display("FAIL %s mosi_word: got %h, expected %h", tag, cap, tx & mask); end
        if (pulse_chk) begin
            @(negedge clk);
            checks++;
            if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s pulse_width: rx_valid got %b, expected 0", tag, rx_valid); end
        end
    endtask

    task automatic test_reset();
        cpol = 1'b0; cpha = 1'b0; start_cmd = 1'b0; n_clks = 6'd8; clk_div = '0;
        ss_sel = '0; tx_data = '0; sreset = 1'b1;
`ifdef SPI_MASTER_LSB_FIRST_EN
        lsb_first = 1'b0;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (spi_drv_rdy !== 1'b1 || rx_valid !== 1'b0 || rx_miso !== '0) begin
            errors++; $display("FAIL reset_status: got rdy=%b valid=%b rx=%h, expected 1 0 0", spi_drv_rdy, rx_valid, rx_miso);
        end
        checks++;
        if (SS_N !== '1 || SCLK !== 1'b0 || MOSI !== 1'b0) begin
            errors++; $display("FAIL reset_pins: got ss=%b sclk=%b mosi=%b, expected all1 0 0", SS_N, SCLK, MOSI);
        end
        sreset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0_loopback();
        @(negedge clk);
        run_xfer(8, 2, 1'b0, 1'b0, 0, 32'hA5, 1'b1, 1'b0, 1'b0, 1'b1, "mode0_a5");
    endtask

    task automatic test_mode3();
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (SCLK !== 1'b1) begin errors++; $display("FAIL mode3_idle_before: got %b, expected 1", SCLK); end
        run_xfer(32, 1, 1'b1, 1'b1, 1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1, "mode3");
        checks++;
        if (SCLK !== 1'b1) begin errors++; $display("FAIL mode3_idle_after: got %b, expected 1", SCLK); end
        cpol = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ss_sel();
        @(negedge clk);
        run_xfer(4, 3, 1'b0, 1'b1, 2, 32'h9, 1'b0, 1'b0, 1'b0, 1'b1, "sel2");
    endtask

    task automatic test_abort();
        int pulses;
        @(negedge clk);
        cur_n = 16; cur_cpha = 1'b0; cur_lsb = 1'b0; loop_en = 1'b1;
        n_clks = 6'd16; clk_div = DW'(2); cpol = 1'b0; cpha = 1'b0; ss_sel = 2'd0;
        tx_data = $urandom; start_cmd = 1'b1;
        @(posedge clk); #1;
        start_cmd = 1'b0;
        repeat (34) @(negedge clk);
        checks++;
        if (SS_N === '1) begin errors++; $display("FAIL abort_midflight: got ss=%b, expected a low select", SS_N); end
        sreset = 1'b1;
        @(negedge clk);
        checks++;
        if (SS_N !== '1 || SCLK !== 1'b0 || spi_drv_rdy !== 1'b1 || rx_valid !== 1'b0 || MOSI !== 1'b0) begin
            errors++; $display("FAIL abort_pins: got ss=%b sclk=%b rdy=%b valid=%b mosi=%b, expected all1 0 1 0 0",
                               SS_N, SCLK, spi_drv_rdy, rx_valid, MOSI);
        end
        sreset = 1'b0;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (rx_valid === 1'b1 || SS_N !== '1) pulses++;
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles, expected 0", pulses); end
    endtask

    task automatic test_illegal();
        int bad;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_clks = (c == 0) ? 6'd0 : ((c == 1) ? 6'd33 : 6'd8);
            ss_sel = (c == 2) ? 2'd3 : 2'd0;
            clk_div = DW'(1); cpol = 1'b0; cpha = 1'b0; tx_data = 32'hFFFF_FFFF;
            start_cmd = 1'b1;
            @(negedge clk);
            start_cmd = 1'b0;
            bad = 0;
            repeat (10) begin
                if (spi_drv_rdy !== 1'b1 || SS_N !== '1 || rx_valid !== 1'b0 || SCLK !== 1'b0 || MOSI !== 1'b0) bad++;
                @(negedge clk);
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL illegal_cmd_%0d: got %0d non-idle cycles, expected 0", c, bad); end
        end
    endtask

    task automatic test_busy_ignored();
        int bad;
        @(negedge clk);
        run_xfer(6, 2, 1'b0, 1'b0, 1, 32'h2D, 1'b0, 1'b0, 1'b1, 1'b1, "busy_poke");
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_drv_rdy !== 1'b1 || SS_N !== '1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL busy_not_queued: got %0d busy cycles, expected 0", bad); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        run_xfer(5, 1, 1'b0, 1'b1, 0, 32'h15, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_first");
        run_xfer(7, 2, 1'b0, 1'b0, 2, 32'h4B, 1'b1, 1'b0, 1'b0, 1'b1, "b2b_second");
    endtask

    task automatic test_random();
        logic lsb;
        for (int i = 0; i < 15; i++) begin
            lsb = 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
            lsb = 1'($urandom_range(0, 1));
`endif
            cpol = 1'($urandom_range(0, 1));
            @(negedge clk);
            @(negedge clk);
            run_xfer($urandom_range(1, 32), $urandom_range(0, 3), cpol, 1'($urandom_range(0, 1)),
                     $urandom_range(0, NSS - 1), $urandom, 1'($urandom_range(0, 1)), lsb,
                     1'b0, 1'b1, $sformatf("rand%0d", i));
        end
        cpol = 1'b0;
    endtask

`ifdef SPI_MASTER_LSB_FIRST_EN
    task automatic test_lsb_first();
        @(negedge clk);
        run_xfer(8, 2, 1'b0, 1'b0, 0, 32'h01, 1'b1, 1'b1, 1'b0, 1'b1, "lsb_first");
        checks++;
        if (first_cap !== 1'b1) begin errors++; $display("FAIL lsb_first_bit: got %b, expected 1", first_cap); end
    endtask
`endif

    initial begin
        sreset = 1'b1;
        start_cmd = 1'b0;
        test_reset();
        test_mode0_loopback();
        test_mode3();
        test_ss_sel();
        test_illegal();
        test_busy_ignored();
        test_back_to_back();
        test_abort();
        test_random();
`ifdef SPI_MASTER_LSB_FIRST_EN
        test_lsb_first();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
